ifm_scan_ctrl: RTL and testbench
================================

Name: ifm_scan_ctrl

Overview:
- Sequencer that drives the 3x3 IFM window buffer for a convolution engine.
- Walks a window over one H x W IFM channel in serpentine order and fetches pixels from a byte-wide IFM SRAM.
- Packs each fetch into the buffer's 32-bit command word: opcode in [31:24], three pixels in [23:0].
- Flags each completed window to the PE array with a valid/ready handshake.

Parameters:
- ADDR_W, 16, IFM SRAM byte address width.
- DIM_W, 8, width of height/width config and of window coordinates.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latches cfg_* and begins a frame; ignored while busy
- cfg_h  in  DIM_W  IFM height H, valid if >=3
- cfg_w  in  DIM_W  IFM width W, valid if >=3
- cfg_base  in  ADDR_W  SRAM address of pixel (0,0); row-major layout
- mem_rd_en  out  1  SRAM read strobe
- mem_addr  out  ADDR_W  SRAM read address
- mem_rd_data  in  8  SRAM data, valid one cycle after mem_rd_en
- buf_valid  out  1  one-cycle write strobe to the window buffer
- buf_word  out  32  command word: opcode[31:24], pixels p0[23:16], p1[15:8], p2[7:0]
- win_valid  out  1  buffer holds a complete new window
- win_ready  in  1  PE array accepts the window
- win_row  out  DIM_W  top-left row of the current window
- win_col  out  DIM_W  top-left column of the current window
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse at frame end
- err  out  1  one-cycle pulse with done when cfg_h<3 or cfg_w<3

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; internal counters cleared. Reset mid-frame aborts the frame immediately, with no done pulse.
- Opcodes: LOAD=0x00, SHR=0x01 (new right column), SHL=0x02 (new left column), DOWN=0xFF (new bottom row).
- Column words (LOAD/SHR/SHL) carry rows r..r+2 of one column: p0=r, p1=r+1, p2=r+2.
- DOWN words carry columns c..c+2 of row r+3: p0=c, p1=c+1, p2=c+2.
- Pixel address = cfg_base + row*W + col, truncated to ADDR_W. Computed from a row-base register, incremented by W per row; no multiplier.
- FSM states: IDLE -> FETCH -> LAST -> ISSUE -> (WIN) -> FETCH | FIN -> IDLE.
- FETCH: three cycles, mem_rd_en=1, pixel k=0,1,2 addressed on consecutive cycles.
- LAST: captures the third data byte.
- ISSUE: buf_valid=1 for exactly one cycle with the complete buf_word.
- WIN: entered only if the issued word completes a window. win_valid=1 from the cycle after ISSUE; held with win_row/win_col stable until win_ready is sampled high; next FETCH begins the cycle after acceptance.
- Word cadence: 5 cycles per word with no window, 6+ with a window.
- Window-completing words: the third LOAD word, and every SHR, SHL and DOWN word.
- Scan order:
  - LOAD cols 0,1,2 -> window (0,0).
  - SHR cols 3..W-1 -> windows (0,1)..(0,W-3).
  - If rows remain, DOWN, then SHL cols W-4..0 -> windows (1,W-3)..(1,0).
  - DOWN, then SHR, alternating per band until window row H-3 is complete.
- W=3: no SHR/SHL words; successive DOWN words only. H=3: single band, no DOWN.
- Totals: (H-2)*(W-2) windows; 3 + (W-3) + (H-3)*(W-2) words.
- LOAD is issued only at frame start; the downstream buffer must be reset between frames.
- FIN: done=1 for one cycle, busy drops in the same cycle, then IDLE.
- Bad config: start with cfg_h<3 or cfg_w<3 gives done=1 and err=1 on the next cycle, with no memory reads.
- busy=1 from the cycle after an accepted start through the FIN cycle. A start pulse arriving while busy has no effect.

Decomposition:
- Package ifm_scan_pkg: opcode constants LOAD/SHR/SHL/DOWN, state enum, and a direction typedef (dir_e: RIGHT/LEFT).
- Sub-module ifm_addr_gen: holds row-base and column counters, produces mem_addr for each requested (row, col).

Test Plan:
- H=W=4, base=0, mem[r*4+c]=r*16+c, win_ready=1 -> buf_word sequence 0x00001020, 0x00011121, 0x00021222, 0x01031323, 0xFF313233, 0x02102030; windows in order (0,0),(0,1),(1,1),(1,0); done after the last window.
- H=3, W=5 -> 3 LOAD + 2 SHR words, no DOWN; windows (0,0),(0,1),(0,2); exactly 15 mem_rd_en cycles.
- H=5, W=3 -> 3 LOAD then DOWN words for rows 3 and 4 with p0..p2=cols 0..2; windows (0,0),(1,0),(2,0).
- H=W=4, win_ready held low 10 cycles on the first window -> win_valid, win_row, win_col stable; no mem_rd_en or buf_valid until acceptance.
- cfg_h=2 start -> done=1 and err=1 next cycle, busy never asserted, mem_rd_en=0.
- rst_n asserted during the 2nd SHR fetch of an H=W=6 frame -> all outputs 0 immediately; a subsequent start reruns the frame from LOAD.

Source files
------------

// File: rtl/ifm_scan_pkg.sv
// rtl/ifm_scan_pkg.sv - opcodes, FSM states and scan direction for the IFM scan sequencer
package ifm_scan_pkg;

    localparam logic [7:0] OP_LOAD = 8'h00;
    localparam logic [7:0] OP_SHR  = 8'h01;
    localparam logic [7:0] OP_SHL  = 8'h02;
    localparam logic [7:0] OP_DOWN = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LAST,
        ST_ISSUE,
        ST_WIN,
        ST_FIN
    } state_e;

    typedef enum logic {
        RIGHT,
        LEFT
    } dir_e;

endpackage

// File: rtl/ifm_addr_gen.sv
// rtl/ifm_addr_gen.sv - IFM pixel address from a band row-base register plus row/column offsets
module ifm_addr_gen #(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init,
    input  logic [ADDR_W-1:0] base,
    input  logic [DIM_W-1:0]  w,
    input  logic              row_step,
    input  logic [1:0]        dr,
    input  logic [DIM_W-1:0]  col,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] row_base;
    logic [ADDR_W-1:0] stride;
    logic [ADDR_W-1:0] row_off;

    // row_base tracks base + top_row*W; it only ever advances by one stride
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_base <= '0;
            stride   <= '0;
        end else if (init) begin
            row_base <= base;
            stride   <= ADDR_W'(w);
        end else if (row_step) begin
            row_base <= row_base + stride;
        end
    end

    always_comb begin
        row_off = '0;
        case (dr)
            2'd0: row_off = '0;
            2'd1: row_off = stride;
            2'd2: row_off = stride << 1;
            2'd3: row_off = stride + (stride << 1);
            default: row_off = '0;
        endcase
    end

    assign addr = row_base + row_off + ADDR_W'(col);

endmodule

// File: rtl/ifm_scan_ctrl.sv
// rtl/ifm_scan_ctrl.sv - serpentine 3x3 window scan sequencer feeding the IFM window buffer
module ifm_scan_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DIM_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DIM_W-1:0]  cfg_h,
    input  logic [DIM_W-1:0]  cfg_w,
    input  logic [ADDR_W-1:0] cfg_base,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              buf_valid,
    output logic [31:0]       buf_word,
    output logic              win_valid,
    input  logic              win_ready,
    output logic [DIM_W-1:0]  win_row,
    output logic [DIM_W-1:0]  win_col,
    output logic              busy,
    output logic              done,
    output logic              err
);
    import ifm_scan_pkg::*;

    state_e           state;
    dir_e             dir_q, nxt_dir;
    logic [1:0]       fk;
    logic [DIM_W-1:0] h_q, w_q;
    logic [7:0]       op_q, p0_q, p1_q, nxt_op;
    // fc_q: column (or first column for DOWN) of the word being fetched; nr/nc: window it completes
    logic [DIM_W-1:0] fc_q, nr_q, nc_q;
    logic [DIM_W-1:0] nxt_fc, nxt_nr, nxt_nc;
    logic             fin_q, nxt_fin, win_done;
    logic             cfg_ok, ag_init, ag_row_step;
    logic [1:0]       ag_dr;
    logic [DIM_W-1:0] ag_col;
    logic [DIM_W:0]   nc_p3, nr_p3;

    assign cfg_ok      = (cfg_h >= DIM_W'(3)) && (cfg_w >= DIM_W'(3));
    assign ag_init     = (state == ST_IDLE) && start && cfg_ok;
    assign ag_row_step = (state == ST_ISSUE) && (op_q == OP_DOWN);
    assign ag_dr       = (op_q == OP_DOWN) ? 2'd3 : fk;
    assign ag_col      = (op_q == OP_DOWN) ? fc_q + DIM_W'(fk) : fc_q;
    assign win_done    = !((op_q == OP_LOAD) && (fc_q != DIM_W'(2)));
    assign nc_p3       = {1'b0, nc_q} + (DIM_W+1)'(3);
    assign nr_p3       = {1'b0, nr_q} + (DIM_W+1)'(3);

    ifm_addr_gen #(
        .ADDR_W (ADDR_W),
        .DIM_W  (DIM_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .init     (ag_init),
        .base     (cfg_base),
        .w        (cfg_w),
        .row_step (ag_row_step),
        .dr       (ag_dr),
        .col      (ag_col),
        .addr     (mem_addr)
    );

    // Plan the word after the one being issued, from the window it completes
    always_comb begin
        nxt_op  = op_q;
        nxt_fc  = fc_q;
        nxt_nr  = nr_q;
        nxt_nc  = nc_q;
        nxt_dir = dir_q;
        nxt_fin = 1'b0;
        if (!win_done) begin
            nxt_fc = fc_q + DIM_W'(1);
        end else if ((dir_q == RIGHT) && (nc_p3 < {1'b0, w_q})) begin
            nxt_op = OP_SHR;
            nxt_fc = nc_q + DIM_W'(3);
            nxt_nc = nc_q + DIM_W'(1);
        end else if ((dir_q == LEFT) && (nc_q != '0)) begin
            nxt_op = OP_SHL;
            nxt_fc = nc_q - DIM_W'(1);
            nxt_nc = nc_q - DIM_W'(1);
        end else if (nr_p3 < {1'b0, h_q}) begin
            nxt_op  = OP_DOWN;
            nxt_fc  = nc_q;
            nxt_nr  = nr_q + DIM_W'(1);
            nxt_dir = (dir_q == RIGHT) ? LEFT : RIGHT;
        end else begin
            nxt_fin = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            dir_q     <= RIGHT;
            fk        <= '0;
            h_q       <= '0;
            w_q       <= '0;
            op_q      <= OP_LOAD;
            p0_q      <= '0;
            p1_q      <= '0;
            fc_q      <= '0;
            nr_q      <= '0;
            nc_q      <= '0;
            fin_q     <= 1'b0;
            mem_rd_en <= 1'b0;
            buf_valid <= 1'b0;
            buf_word  <= '0;
            win_valid <= 1'b0;
            win_row   <= '0;
            win_col   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    err  <= 1'b0;
                    if (start) begin
                        h_q <= cfg_h;
                        w_q <= cfg_w;
                        if (!cfg_ok) begin
                            done <= 1'b1;
                            err  <= 1'b1;
                        end else begin
                            busy      <= 1'b1;
                            op_q      <= OP_LOAD;
                            fc_q      <= '0;
                            nr_q      <= '0;
                            nc_q      <= '0;
                            dir_q     <= RIGHT;
                            fin_q     <= 1'b0;
                            fk        <= '0;
                            mem_rd_en <= 1'b1;
                            state     <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (fk == 2'd1) p0_q <= mem_rd_data;
                    if (fk == 2'd2) begin
                        p1_q      <= mem_rd_data;
                        mem_rd_en <= 1'b0;
                        state     <= ST_LAST;
                    end else begin
                        fk <= fk + 2'd1;
                    end
                end
                ST_LAST: begin
                    buf_word  <= {op_q, p0_q, p1_q, mem_rd_data};
                    buf_valid <= 1'b1;
                    state     <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    buf_valid <= 1'b0;
                    op_q      <= nxt_op;
                    fc_q      <= nxt_fc;
                    nr_q      <= nxt_nr;
                    nc_q      <= nxt_nc;
                    dir_q     <= nxt_dir;
                    fin_q     <= nxt_fin;
                    if (win_done) begin
                        win_valid <= 1'b1;
                        win_row   <= nr_q;
                        win_col   <= nc_q;
                        state     <= ST_WIN;
                    end else begin
                        fk        <= '0;
                        mem_rd_en <= 1'b1;
                        state     <= ST_FETCH;
                    end
                end
                ST_WIN: begin
                    if (win_ready) begin
                        win_valid <= 1'b0;
                        if (fin_q) begin
                            done  <= 1'b1;
                            state <= ST_FIN;
                        end else begin
                            fk        <= '0;
                            mem_rd_en <= 1'b1;
                            state     <= ST_FETCH;
                        end
                    end
                end
                ST_FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ifm_scan_ctrl.sv
// tb/tb_ifm_scan_ctrl.sv - randomized self-checking bench for ifm_scan_ctrl against a scan-order model
module tb_ifm_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  cfg_h = '0;
    logic [7:0]  cfg_w = '0;
    logic [15:0] cfg_base = '0;
    logic        mem_rd_en;
    logic [15:0] mem_addr;
    logic [7:0]  mem_rd_data = '0;
    logic        buf_valid;
    logic [31:0] buf_word;
    logic        win_valid;
    logic        win_ready;
    logic [7:0]  win_row;
    logic [7:0]  win_col;
    logic        busy;
    logic        done;
    logic        err;

    logic [7:0]  mem [0:65535];
    int          n_vec = 0;
    int          n_err = 0;
    int          rdy_mode = 0;
    logic        mon_clr = 1'b0;

    logic [31:0] got_words[$];
    logic [15:0] got_wins[$];
    int          rd_cnt, busy_cnt, stab_viol, first_hold;
    logic        pend;
    logic [7:0]  pend_row, pend_col;

    ifm_scan_ctrl #(.ADDR_W(16), .DIM_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cfg_h       (cfg_h),
        .cfg_w       (cfg_w),
        .cfg_base    (cfg_base),
        .mem_rd_en   (mem_rd_en),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .buf_valid   (buf_valid),
        .buf_word    (buf_word),
        .win_valid   (win_valid),
        .win_ready   (win_ready),
        .win_row     (win_row),
        .win_col     (win_col),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (mon_clr) begin
            got_words.delete();
            got_wins.delete();
            rd_cnt = 0; busy_cnt = 0; stab_viol = 0; first_hold = 0; pend = 1'b0;
        end else begin
            if (buf_valid) got_words.push_back(buf_word);
            if (mem_rd_en) rd_cnt++;
            if (busy) busy_cnt++;
            if (win_valid) begin
                if (got_wins.size() == 0) first_hold++;
                if (pend && (win_row != pend_row || win_col != pend_col)) stab_viol++;
                if (mem_rd_en || buf_valid) stab_viol++;
                if (win_ready) begin
                    got_wins.push_back({win_row, win_col});
                    pend = 1'b0;
                end else begin
                    pend = 1'b1; pend_row = win_row; pend_col = win_col;
                end
            end
        end
    end

    initial begin
        int stall_left;
        stall_left = 10;
        win_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!busy) stall_left = 10;
            case (rdy_mode)
                1: win_ready = 1'($urandom_range(0, 1));
                2: begin
                    win_ready = !(win_valid && stall_left > 0);
                    if (win_valid && stall_left > 0) stall_left--;
                end
                default: win_ready = 1'b1;
            endcase
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_mem_rd_en"}, 32'(mem_rd_en), 0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
        chk({tag, "_buf_valid"}, 32'(buf_valid), 0);
        chk({tag, "_buf_word"}, buf_word, 0);
        chk({tag, "_win_valid"}, 32'(win_valid), 0);
        chk({tag, "_win_rc"}, {16'h0, win_row, win_col}, 0);
        chk({tag, "_busy_done_err"}, {29'h0, busy, done, err}, 0);
    endtask

    function automatic logic [7:0] pix(input logic [15:0] base, input int w, input int r, input int c);
        return mem[16'(int'(base) + r * w + c)];
    endfunction

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk); #1;
        mon_clr = 1'b0;
    endtask

    task automatic pulse_start(input int h, input int w, input logic [15:0] base);
        @(posedge clk); #1;
        cfg_h = 8'(h); cfg_w = 8'(w); cfg_base = base; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_frame(input int h, input int w, input logic [15:0] base, input int mode, input string tag);
        logic [31:0] ew[$];
        logic [15:0] ewin[$];
        int c, n, nw;
        logic seen, busy_at_done, err_at_done;
        for (int k = 0; k < 3; k++)
            ew.push_back({8'h00, pix(base, w, 0, k), pix(base, w, 1, k), pix(base, w, 2, k)});
        ewin.push_back(16'h0000);
        c = 0;
        for (int r = 0; r <= h - 3; r++) begin
            if (r > 0) begin
                ew.push_back({8'hFF, pix(base, w, r + 2, c), pix(base, w, r + 2, c + 1), pix(base, w, r + 2, c + 2)});
                ewin.push_back({8'(r), 8'(c)});
            end
            if (r % 2 == 0) begin
                while (c < w - 3) begin
                    c++;
                    ew.push_back({8'h01, pix(base, w, r, c + 2), pix(base, w, r + 1, c + 2), pix(base, w, r + 2, c + 2)});
                    ewin.push_back({8'(r), 8'(c)});
                end
            end else begin
                while (c > 0) begin
                    c--;
                    ew.push_back({8'h02, pix(base, w, r, c), pix(base, w, r + 1, c), pix(base, w, r + 2, c)});
                    ewin.push_back({8'(r), 8'(c)});
                end
            end
        end
        rdy_mode = mode;
        clear_mon();
        pulse_start(h, w, base);
        @(negedge clk);
        chk({tag, "_busy_rise"}, 32'(busy), 1);
        seen = 1'b0; busy_at_done = 1'b0; err_at_done = 1'b1;
        for (n = 0; n < 4000 && !seen; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1; busy_at_done = busy; err_at_done = err;
            end
        end
        chk({tag, "_done_seen"}, 32'(seen), 1);
        chk({tag, "_busy_at_done"}, 32'(busy_at_done), 1);
        chk({tag, "_err_at_done"}, 32'(err_at_done), 0);
        @(negedge clk);
        chk({tag, "_busy_done_after"}, {30'h0, busy, done}, 0);
        chk({tag, "_n_words"}, 32'(got_words.size()), 32'(3 + (w - 3) + (h - 3) * (w - 2)));
        chk({tag, "_n_wins"}, 32'(got_wins.size()), 32'((h - 2) * (w - 2)));
        chk({tag, "_n_reads"}, 32'(rd_cnt), 32'(3 * ew.size()));
        chk({tag, "_stall_stable"}, 32'(stab_viol), 0);
        nw = (got_words.size() < ew.size()) ? got_words.size() : ew.size();
        for (int i = 0; i < nw; i++) chk($sformatf("%s_word%0d", tag, i), got_words[i], ew[i]);
        nw = (got_wins.size() < ewin.size()) ? got_wins.size() : ewin.size();
        for (int i = 0; i < nw; i++) chk($sformatf("%s_win%0d", tag, i), 32'(got_wins[i]), 32'(ewin[i]));
        if (mode == 0) chk({tag, "_first_hold"}, 32'(first_hold), 1);
        if (mode == 2) chk({tag, "_first_hold"}, 32'(first_hold), 11);
    endtask

    task automatic run_bad(input int h, input int w, input string tag);
        rdy_mode = 0;
        clear_mon();
        pulse_start(h, w, 16'h0010);
        @(negedge clk);
        chk({tag, "_done_err"}, {30'h0, done, err}, 32'h3);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_rd_en"}, 32'(mem_rd_en), 0);
        @(negedge clk);
        chk({tag, "_done_err_clr"}, {30'h0, done, err}, 0);
        repeat (4) @(negedge clk);
        chk({tag, "_no_reads"}, 32'(rd_cnt), 0);
        chk({tag, "_no_busy"}, 32'(busy_cnt), 0);
    endtask

    initial begin
        logic [31:0] tp_words [6];
        logic [15:0] tp_wins [4];
        logic seen;
        tp_words = '{32'h00001020, 32'h00011121, 32'h00021222, 32'h01031323, 32'hFF313233, 32'h02102030};
        tp_wins  = '{16'h0000, 16'h0001, 16'h0101, 16'h0100};
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) mem[r * 4 + c] = 8'(r * 16 + c);

        repeat (3) @(negedge clk);
        chk_idle_outputs("in_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle_outputs("after_reset");

        run_frame(4, 4, 16'h0000, 0, "h4w4");
        for (int i = 0; i < 6 && i < got_words.size(); i++) chk($sformatf("tp_word%0d", i), got_words[i], tp_words[i]);
        for (int i = 0; i < 4 && i < got_wins.size(); i++) chk($sformatf("tp_win%0d", i), 32'(got_wins[i]), 32'(tp_wins[i]));
        run_frame(3, 5, 16'h0100, 0, "h3w5");
        chk("h3w5_reads15", 32'(rd_cnt), 15);
        run_frame(5, 3, 16'h0200, 0, "h5w3");
        run_frame(4, 4, 16'h0000, 2, "stall");
        run_bad(2, 6, "bad_h");
        run_bad(7, 1, "bad_w");

        // abort a 6x6 frame during the fetch of its second SHR word
        rdy_mode = 0;
        clear_mon();
        pulse_start(6, 6, 16'h0040);
        seen = 1'b0;
        for (int n = 0; n < 400 && !seen; n++) begin
            @(negedge clk);
            if (got_words.size() == 4 && mem_rd_en) seen = 1'b1;
        end
        chk("abort_reached", 32'(seen), 1);
        #2 rst_n = 1'b0;
        #1 chk_idle_outputs("abort");
        repeat (2) @(negedge clk);
        chk_idle_outputs("abort_hold");
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_frame(6, 6, 16'h0040, 0, "rerun");

        for (int t = 0; t < 6; t++)
            run_frame(int'($urandom_range(3, 9)), int'($urandom_range(3, 9)),
                      (t == 0) ? 16'hFFF0 : 16'($urandom), 1, $sformatf("rand%0d", t));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
